// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED PIO arbiter.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_ADDR_W = 2;
    localparam int unsigned DEF_DATA_W = 32;

    // Round-robin successor of idx, wrapping at n.
    function automatic int unsigned rr_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               any_req,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 found;

    // Rotating a doubled vector puts rr_ptr at bit 0; the lowest set bit then wins.
    always_comb begin
        req_dbl   = {req, req};
        req_rot   = NUM_REQ'(req_dbl >> rr_ptr);
        any_req   = |req;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_rot[i]) begin
                found     = 1'b1;
                grant_idx = IDX_W'((i + 32'(rr_ptr)) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/led_pio_arbiter.sv
// Round-robin sharing of one zero-wait-state Avalon-MM LED PIO among NUM_REQ cores.
module led_pio_arbiter
    import led_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_chipselect,
    input  logic [NUM_REQ-1:0]        req_write_n,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic                      pio_chipselect,
    output logic                      pio_write_n,
    output logic [ADDR_W-1:0]         pio_address,
    output logic [DATA_W-1:0]         pio_writedata,
    input  logic [DATA_W-1:0]         pio_readdata
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_e       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic             any_req;
    logic [IDX_W-1:0] arb_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_chipselect),
        .rr_ptr    (rr_ptr),
        .any_req   (any_req),
        .grant_idx (arb_idx)
    );

    // Only the granted core is released, and only during RESP.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_waitrequest[i] = req_chipselect[i]
                                 & ~((state == RESP) && (32'(grant_idx) == i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant_idx      <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_address    <= '0;
            pio_writedata  <= '0;
            req_readdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_idx      <= arb_idx;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= req_write_n[arb_idx];
                        pio_address    <= req_address[int'(arb_idx)*ADDR_W +: ADDR_W];
                        pio_writedata  <= req_writedata[int'(arb_idx)*DATA_W +: DATA_W];
                        state          <= ISSUE;
                    end else begin
                        pio_chipselect <= 1'b0;
                    end
                end
                ISSUE: begin
                    // PIO is zero-wait-state, so read data is valid in this cycle.
                    if (pio_write_n) begin
                        req_readdata <= pio_readdata;
                    end
                    pio_chipselect <= 1'b0;
                    pio_write_n    <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    rr_ptr <= IDX_W'(rr_inc(32'(grant_idx), NUM_REQ));
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Directed and randomized checks of led_pio_arbiter against a transaction-level model.
module tb_led_pio_arbiter;

    localparam int N = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    cs;
    logic [N-1:0]    wn;
    logic [N*2-1:0]  addr;
    logic [N*32-1:0] wdata;
    logic [N-1:0]    req_waitrequest;
    logic [31:0]     req_readdata;
    logic            pio_chipselect;
    logic            pio_write_n;
    logic [1:0]      pio_address;
    logic [31:0]     pio_writedata;
    logic [31:0]     pio_readdata;

    int          tests = 0;
    int          fails = 0;
    int          m_ptr = 0;
    logic [31:0] m_rdata = '0;

    led_pio_arbiter #(.NUM_REQ(N), .ADDR_W(2), .DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_chipselect  (cs),
        .req_write_n     (wn),
        .req_address     (addr),
        .req_writedata   (wdata),
        .req_waitrequest (req_waitrequest),
        .req_readdata    (req_readdata),
        .pio_chipselect  (pio_chipselect),
        .pio_write_n     (pio_write_n),
        .pio_address     (pio_address),
        .pio_writedata   (pio_writedata),
        .pio_readdata    (pio_readdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: first requesting core found by walking ptr, ptr+1, ... mod N.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_core(input int c, input logic w_n, input logic [1:0] a, input logic [31:0] d);
        wn[c]            = w_n;
        addr[c*2 +: 2]   = a;
        wdata[c*32 +: 32] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_ptr   = 0;
        m_rdata = '0;
    endtask

    // One arbitration round starting in IDLE; ends back in IDLE.
    task automatic txn(input logic [31:0] rd, input bit drop_issue, input bit churn);
        int          w;
        logic        exp_wn;
        logic [N-1:0] oh;
        w = pick(cs, m_ptr);
        if (w < 0) begin
            tick();
            chk("idle_cs", 32'(pio_chipselect), 32'd0);
            chk("idle_wait", 32'(req_waitrequest), 32'(cs));
            return;
        end
        oh    = '0;
        oh[w] = 1'b1;
        tick();
        chk("iss_cs", 32'(pio_chipselect), 32'd1);
        chk("iss_wn", 32'(pio_write_n), 32'(wn[w]));
        chk("iss_addr", 32'(pio_address), 32'(addr[w*2 +: 2]));
        chk("iss_data", pio_writedata, wdata[w*32 +: 32]);
        chk("iss_wait", 32'(req_waitrequest), 32'(cs));
        exp_wn       = wn[w];
        pio_readdata = rd;
        if (drop_issue) cs[w] = 1'b0;
        if (churn) begin
            cs = cs ^ (N'($urandom) & ~oh);
            set_core(w, 1'($urandom), 2'($urandom), $urandom);
        end
        tick();
        chk("rsp_cs", 32'(pio_chipselect), 32'd0);
        chk("rsp_wn", 32'(pio_write_n), 32'd1);
        if (exp_wn) m_rdata = rd;
        chk("rsp_rdata", req_readdata, m_rdata);
        chk("rsp_wait", 32'(req_waitrequest), 32'(cs & ~oh));
        cs[w] = 1'b0;
        tick();
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        reset        = 1'b1;
        cs           = '0;
        wn           = '1;
        addr         = '0;
        wdata        = '0;
        pio_readdata = '0;
        for (int c = 0; c < N; c++) set_core(c, 1'b1, 2'd0, 32'h1000_0000 + 32'(c));

        do_reset();
        chk("rst_cs", 32'(pio_chipselect), 32'd0);
        chk("rst_wn", 32'(pio_write_n), 32'd1);
        chk("rst_addr", 32'(pio_address), 32'd0);
        chk("rst_data", pio_writedata, 32'd0);
        chk("rst_rdata", req_readdata, 32'd0);
        chk("rst_wait", 32'(req_waitrequest), 32'd0);

        // 1: core 3 writes 0xA5 to address 0
        set_core(3, 1'b0, 2'd0, 32'h0000_00A5);
        cs[3] = 1'b1;
        txn(32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("t1_rdata_hold", req_readdata, 32'd0);

        // 2: core 5 reads 0x3C while core 2 waits
        set_core(5, 1'b1, 2'd0, 32'h0);
        cs[5] = 1'b1;
        cs[2] = 1'b1;
        txn(32'h0000_003C, 1'b0, 1'b0);
        chk("t2_rdata", req_readdata, 32'h0000_003C);
        txn(32'h1234_5678, 1'b0, 1'b0);

        // 3: all cores at once after reset, served 0..7
        do_reset();
        for (int c = 0; c < N; c++) set_core(c, 1'(c & 1), 2'(c), 32'hA000_0000 + 32'(c));
        cs = '1;
        for (int r = 0; r < N; r++) txn($urandom, 1'b0, 1'b0);
        chk("t3_ptr", 32'(dut.rr_ptr), 32'(m_ptr));

        // 4: bring rr_ptr to 6, then cores 2 and 7 contend with 7 re-requesting
        cs[5] = 1'b1;
        txn($urandom, 1'b0, 1'b0);
        cs[2] = 1'b1;
        cs[7] = 1'b1;
        txn($urandom, 1'b0, 1'b0);
        cs[7] = 1'b1;
        txn($urandom, 1'b0, 1'b0);
        chk("t4_core7_waiting", 32'(req_waitrequest), 32'h80);
        txn($urandom, 1'b0, 1'b0);

        // 5: core 1 drops chipselect during ISSUE
        set_core(1, 1'b0, 2'd0, 32'h0000_0055);
        cs[1] = 1'b1;
        txn($urandom, 1'b1, 1'b0);
        chk("t5_ptr", 32'(dut.rr_ptr), 32'd2);
        chk("t5_state", 32'(dut.state), 32'd0);

        // 6: reset while in RESP
        set_core(4, 1'b0, 2'd1, 32'h0000_0077);
        cs[4] = 1'b1;
        tick();
        chk("t6_iss_cs", 32'(pio_chipselect), 32'd1);
        tick();
        chk("t6_rsp_wait", 32'(req_waitrequest), 32'd0);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        m_ptr   = 0;
        m_rdata = '0;
        chk("t6_cs", 32'(pio_chipselect), 32'd0);
        chk("t6_wn", 32'(pio_write_n), 32'd1);
        chk("t6_addr", 32'(pio_address), 32'd0);
        chk("t6_data", pio_writedata, 32'd0);
        chk("t6_rdata", req_readdata, 32'd0);
        chk("t6_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("t6_state", 32'(dut.state), 32'd0);
        chk("t6_wait", 32'(req_waitrequest), 32'h10);
        txn($urandom, 1'b0, 1'b0);

        // Randomized traffic with chipselect churn and late drops
        for (int r = 0; r < 60; r++) begin
            for (int c = 0; c < N; c++) set_core(c, 1'($urandom), 2'($urandom), $urandom);
            cs = cs | (N'($urandom) & N'($urandom));
            txn($urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
